// File: rtl/aes_blok_paketleyici_pkg.sv
// Shared definitions for the AES plaintext block packer: widths, FIFO entry
// layout, accumulator word index and the block assembly helper.
package aes_paket;

  localparam int unsigned BLOK_W        = 128;
  localparam int unsigned KELIME_W      = 32;
  localparam int unsigned KELIME_SAYISI = 4;
  localparam int unsigned GIRIS_W       = BLOK_W + 1;

  // FIFO entry: final-block tag above the 128-bit plaintext.
  typedef struct packed {
    logic              son;
    logic [BLOK_W-1:0] blok;
  } giris_t;

  // Position of the next word inside the block being assembled.
  typedef enum logic [1:0] {
    IDX0 = 2'd0,
    IDX1 = 2'd1,
    IDX2 = 2'd2,
    IDX3 = 2'd3
  } idx_t;

  // Builds the block being pushed: slots below idx come from the accumulator,
  // slot idx is the current word, higher slots (lower-order bits) are zero.
  function automatic logic [BLOK_W-1:0] blok_olustur(
    input logic [BLOK_W-KELIME_W-1:0] acc,
    input logic [KELIME_W-1:0]        kelime,
    input idx_t                       idx
  );
    logic [BLOK_W-1:0] genis;
    logic [BLOK_W-1:0] b;
    genis = {acc, {KELIME_W{1'b0}}};
    b     = '0;
    for (int unsigned i = 0; i < KELIME_SAYISI; i++) begin
      if (i < 32'(idx)) begin
        b[BLOK_W-1-KELIME_W*i -: KELIME_W] = genis[BLOK_W-1-KELIME_W*i -: KELIME_W];
      end else if (i == 32'(idx)) begin
        b[BLOK_W-1-KELIME_W*i -: KELIME_W] = kelime;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/aes_blok_fifo.sv
// Synchronous block FIFO between the word packer and the AES engine.
// Independent push/pop; full/empty come from a registered occupancy count.
module aes_blok_fifo #(
  parameter int unsigned GENISLIK = 129,
  parameter int unsigned DERINLIK = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic [GENISLIK-1:0] din,
  output logic [GENISLIK-1:0] dout,
  output logic                bos,
  output logic                dolu
);

  localparam int unsigned PW = (DERINLIK > 1) ? $clog2(DERINLIK) : 1;
  localparam int unsigned CW = $clog2(DERINLIK + 1);

  logic [GENISLIK-1:0] mem_q [DERINLIK];
  logic [PW-1:0]       wr_q, wr_d;
  logic [PW-1:0]       rd_q, rd_d;
  logic [CW-1:0]       say_q, say_d;

  // Storage write; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= din;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      say_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      say_q <= say_d;
    end
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    say_d = say_q;
    if (push) wr_d = wr_q + PW'(1);
    if (pop)  rd_d = rd_q + PW'(1);
    unique case ({push, pop})
      2'b10:   say_d = say_q + CW'(1);
      2'b01:   say_d = say_q - CW'(1);
      default: say_d = say_q;
    endcase
  end

  // Head entry and status flags.
  always_comb begin
    dout = mem_q[rd_q];
    bos  = (say_q == '0);
    dolu = (say_q == CW'(DERINLIK));
  end

endmodule

// File: rtl/aes_blok_paketleyici.sv
// Packs a 32-bit valid/ready word stream into 128-bit AES plaintext blocks,
// zero-pads trailing partial blocks, tags message-final blocks and counts
// blocks taken by the engine.
module aes_blok_paketleyici
  import aes_paket::*;
#(
  parameter int unsigned DERINLIK = 2,
  parameter int unsigned SAYAC_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [KELIME_W-1:0] kelime,
  input  logic                k_gecerli,
  input  logic                k_son,
  output logic                k_hazir,
  output logic [BLOK_W-1:0]   blok,
  output logic                g_gecerli,
  input  logic                hazir,
  output logic                blok_son,
  output logic [SAYAC_W-1:0]  blok_sayisi
);

  logic                         aktif_q;
  idx_t                         idx_q, idx_d;
  logic [BLOK_W-KELIME_W-1:0]   acc_q, acc_d;
  logic [SAYAC_W-1:0]           sayac_q, sayac_d;

  logic                         kabul;
  logic                         push;
  logic                         pop;
  giris_t                       fifo_din;
  giris_t                       fifo_bas;
  logic                         fifo_bos;
  logic                         fifo_dolu;

  aes_blok_fifo #(
    .GENISLIK (GIRIS_W),
    .DERINLIK (DERINLIK)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (fifo_din),
    .dout (fifo_bas),
    .bos  (fifo_bos),
    .dolu (fifo_dolu)
  );

  // State register: word index, accumulator, delivered count, out-of-reset flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      aktif_q <= 1'b0;
      idx_q   <= IDX0;
      acc_q   <= '0;
      sayac_q <= '0;
    end else begin
      aktif_q <= 1'b1;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      sayac_q <= sayac_d;
    end
  end

  // Next-state: store words 0..2, close the block on word 3 or on k_son.
  always_comb begin
    idx_d   = idx_q;
    acc_d   = acc_q;
    sayac_d = sayac_q;
    if (pop) begin
      sayac_d = sayac_q + SAYAC_W'(1);
    end
    if (kabul) begin
      if (push) begin
        idx_d = IDX0;
        acc_d = '0;
      end else begin
        unique case (idx_q)
          IDX0:    acc_d[95:64] = kelime;
          IDX1:    acc_d[63:32] = kelime;
          IDX2:    acc_d[31:0]  = kelime;
          default: acc_d        = acc_q;
        endcase
        idx_d = idx_t'(idx_q + 2'd1);
      end
    end
  end

  // Outputs and handshakes; k_hazir depends only on registered state.
  always_comb begin
    k_hazir       = aktif_q && !fifo_dolu;
    kabul         = k_gecerli && k_hazir;
    push          = kabul && ((idx_q == IDX3) || k_son);
    // Below idx 3 a push only happens on k_son, so the tag is k_son either way.
    fifo_din.son  = k_son;
    fifo_din.blok = blok_olustur(acc_q, kelime, idx_q);
    g_gecerli     = !fifo_bos;
    pop           = g_gecerli && hazir;
    blok          = fifo_bos ? '0   : fifo_bas.blok;
    blok_son      = fifo_bos ? 1'b0 : fifo_bas.son;
    blok_sayisi   = sayac_q;
  end

endmodule

// File: tb/tb_aes_blok_paketleyici.sv
// Scoreboard bench for the AES block packer: stimulus feeds a word-list
// reference model that queues expected blocks; a monitor checks the FIFO head.
module tb_aes_blok_paketleyici;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  kelime = '0;
  logic         k_gecerli = 1'b0;
  logic         k_son = 1'b0;
  logic         k_hazir;
  logic [127:0] blok;
  logic         g_gecerli;
  logic         hazir = 1'b0;
  logic         blok_son;
  logic [3:0]   blok_sayisi;

  aes_blok_paketleyici #(
    .DERINLIK (2),
    .SAYAC_W  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .kelime      (kelime),
    .k_gecerli   (k_gecerli),
    .k_son       (k_son),
    .k_hazir     (k_hazir),
    .blok        (blok),
    .g_gecerli   (g_gecerli),
    .hazir       (hazir),
    .blok_son    (blok_son),
    .blok_sayisi (blok_sayisi)
  );

  always #5 clk = ~clk;

  int           n_chk = 0;
  int           n_fail = 0;
  logic [128:0] exp_q[$];
  logic [31:0]  parca[$];
  int unsigned  pop_model = 0;
  bit           rnd_hazir = 1'b0;
  logic [128:0] bas;

  task automatic chk(input string ad, input logic [128:0] gercek, input logic [128:0] beklenen);
    n_chk++;
    if (gercek !== beklenen) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", ad, gercek, beklenen, $time);
    end
  endtask

  // Reference: collect accepted words; a message end or a fourth word closes
  // a block, words are laid out MSB first and missing words are zero.
  task automatic model_accept(input logic [31:0] w, input logic son);
    logic [127:0] b;
    parca.push_back(w);
    if (son || parca.size() == 4) begin
      b = '0;
      for (int i = 0; i < parca.size(); i++) b[127-32*i -: 32] = parca[i];
      exp_q.push_back({son, b});
      parca.delete();
    end
  endtask

  // Offers one word until accepted; returns 1 time unit after the accept edge.
  task automatic send_word(input logic [31:0] w, input logic son);
    bit ok = 1'b0;
    int t = 0;
    k_gecerli = 1'b1;
    kelime    = w;
    k_son     = son;
    while (!ok && t < 300) begin
      @(negedge clk);
      ok = k_hazir;
      @(posedge clk);
      #1;
      t++;
    end
    if (!ok) chk("kabul_zaman_asimi", 129'(0), 129'(1));
    else     model_accept(w, son);
    k_gecerli = 1'b0;
    k_son     = 1'b0;
  endtask

  task automatic send_msg(input int n);
    for (int i = 0; i < n; i++) send_word($urandom, (i == n - 1));
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("bosalma_kalan", 129'(exp_q.size()), 129'(0));
  endtask

  task automatic reset_dut();
    rst       = 1'b1;
    k_gecerli = 1'b0;
    k_son     = 1'b0;
    hazir     = 1'b0;
    exp_q.delete();
    parca.delete();
    pop_model = 0;
    @(posedge clk);
    @(negedge clk);
    chk("reset_k_hazir", 129'(k_hazir), 129'(0));
    chk("reset_g_gecerli", 129'(g_gecerli), 129'(0));
    chk("reset_blok", 129'(blok), 129'(0));
    chk("reset_blok_son", 129'(blok_son), 129'(0));
    chk("reset_blok_sayisi", 129'(blok_sayisi), 129'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_sonrasi_k_hazir", 129'(k_hazir), 129'(1));
  endtask

  // Monitor: head must equal the oldest expected block; pop it on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("g_gecerli", 129'(g_gecerli), 129'(exp_q.size() != 0));
        chk("blok_sayisi", 129'(blok_sayisi), 129'(4'(pop_model)));
        if (g_gecerli && exp_q.size() != 0) begin
          bas = exp_q[0];
          chk("blok", 129'(blok), 129'(bas[127:0]));
          chk("blok_son", 129'(blok_son), 129'(bas[128]));
          if (hazir) begin
            void'(exp_q.pop_front());
            pop_model++;
          end
        end
      end
    end
  end

  // Random engine backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_hazir) hazir = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    reset_dut();

    // FIPS-197 plaintext, engine always ready.
    hazir = 1'b1;
    send_word(32'h00112233, 1'b0);
    send_word(32'h44556677, 1'b0);
    send_word(32'h8899aabb, 1'b0);
    send_word(32'hccddeeff, 1'b1);
    @(negedge clk);
    chk("fips_gecikme", 129'(g_gecerli), 129'(1));
    chk("fips_blok", 129'(blok), 129'(128'h00112233445566778899aabbccddeeff));
    chk("fips_son", 129'(blok_son), 129'(1));
    @(posedge clk);
    @(negedge clk);
    chk("fips_tek_cevrim", 129'(g_gecerli), 129'(0));
    @(posedge clk);
    #1;
    chk("fips_sayac", 129'(blok_sayisi), 129'(1));

    // Partial block with zero padding, then a one-word message.
    send_word(32'hdeadbeef, 1'b0);
    send_word(32'h01020304, 1'b1);
    @(negedge clk);
    chk("kismi_blok", 129'(blok), 129'(128'hdeadbeef010203040000000000000000));
    @(posedge clk);
    #1;
    send_word(32'hcafef00d, 1'b1);
    @(negedge clk);
    chk("sonraki_mesaj", 129'(blok), 129'(128'hcafef00d000000000000000000000000));
    @(posedge clk);
    #1;
    drain();

    // Backpressure: two blocks fill the FIFO, the third waits.
    hazir = 1'b0;
    for (int i = 0; i < 8; i++) send_word(32'h10000000 + 32'(i), (i == 7));
    @(negedge clk);
    chk("dolu_k_hazir", 129'(k_hazir), 129'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bekleme_blok", 129'(blok), 129'(128'h10000000100000011000000210000003));
    @(posedge clk);
    #1;
    fork
      for (int i = 0; i < 4; i++) send_word(32'h20000000 + 32'(i), (i == 3));
      begin
        repeat (6) @(posedge clk);
        #1 hazir = 1'b1;
      end
    join
    drain();

    // Simultaneous push and pop with one block held.
    hazir = 1'b0;
    send_msg(4);
    for (int i = 0; i < 3; i++) send_word(32'h30000000 + 32'(i), 1'b0);
    hazir = 1'b1;
    send_word(32'h30000003, 1'b0);
    hazir = 1'b0;
    @(negedge clk);
    chk("eszamanli_g_gecerli", 129'(g_gecerli), 129'(1));
    chk("eszamanli_k_hazir", 129'(k_hazir), 129'(1));
    chk("eszamanli_blok", 129'(blok), 129'(128'h30000000300000013000000230000003));
    @(posedge clk);
    #1 hazir = 1'b1;
    drain();

    // Reset with a buffered block and a half-built one.
    hazir = 1'b0;
    send_msg(4);
    send_word(32'h40000000, 1'b0);
    send_word(32'h40000001, 1'b0);
    reset_dut();
    hazir = 1'b1;
    for (int i = 0; i < 4; i++) send_word(32'h50000000 + 32'(i), (i == 3));
    drain();

    // Counter wrap with a 4-bit counter.
    reset_dut();
    hazir = 1'b1;
    for (int b = 0; b < 17; b++) send_msg(4);
    drain();
    @(negedge clk);
    chk("sayac_sarma", 129'(blok_sayisi), 129'(1));
    @(posedge clk);
    #1;

    // Random message lengths, idle gaps and engine backpressure.
    rnd_hazir = 1'b1;
    for (int m = 0; m < 30; m++) begin
      send_msg(int'($urandom_range(1, 9)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_hazir = 1'b0;
    @(posedge clk);
    #1 hazir = 1'b1;
    drain();
    chk("artik_kelime", 129'(parca.size()), 129'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_zaman_asimi: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule
